// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch
//   Byte-addressed, little-endian instruction memory for the pipelined CPU,
//   placed between the IF-stage PC register and the IF/ID register.
//   A LOAD/RUN state machine gates program download (word writes) and
//   instruction fetch. Fetches pass through a registered pipeline of
//   LATENCY stages that can be stalled. Misaligned and out-of-range
//   addresses are reported as faults.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (memory contents kept)
//   load_start   pulse: IDLE/RUN -> LOAD (flushes the fetch pipeline)
//   load_we      write one 32-bit word at load_addr (LOAD only)
//   load_addr    byte address of the word to write (must be word aligned)
//   load_data    word to write; load_data[7:0] lands at load_addr
//   load_done    pulse: LOAD -> RUN
//   fetch_req    fetch request (RUN only)
//   fetch_addr   byte address of the instruction (PC)
//   stall        freezes the fetch pipeline and the outputs
//   instr        {mem[a+3], mem[a+2], mem[a+1], mem[a]}, NOP_WORD otherwise
//   instr_valid  instr/fault valid this cycle
//   fault        fault flag, qualified by instr_valid
//   fault_code   0 none, 1 misaligned, 2 out of range
//   ready        1 while in RUN
//   state        0 IDLE, 1 LOAD, 2 RUN
module instr_mem_fetch #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              ready,
  output logic [1:0]        state
);

  localparam int unsigned WORDS  = DEPTH_BYTES / 4;
  localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_ALIGN = 2'd1;
  localparam logic [1:0] CODE_RANGE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Only aligned whole words are ever written or read, so the byte array is
  // held as little-endian words: byte a+k of a word is bits [8k+7:8k].
  logic [31:0] mem_q [WORDS];

  logic [LATENCY-1:0][31:0] dat_q;
  logic [LATENCY-1:0][1:0]  code_q;
  logic [LATENCY-1:0]       vld_q;

  logic        mem_we;
  logic        accept;
  logic        flush;
  logic        run;
  logic [31:0] new_data;
  logic [1:0]  new_code;

  // a+3 < DEPTH, evaluated one bit wider so addresses near the top of the
  // ADDR_W space cannot wrap into range.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} + (ADDR_W + 1)'(3)) < DEPTH_EXT;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load_start) state_d = ST_LOAD;
      ST_LOAD: if (load_done)  state_d = ST_RUN;
      ST_RUN:  if (load_start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    accept = 1'b0;
    flush  = 1'b0;
    run    = 1'b0;
    unique case (state_q)
      ST_IDLE: flush = load_start;
      ST_LOAD: mem_we = load_we && (load_addr[1:0] == 2'b00) && in_range(load_addr);
      ST_RUN: begin
        run    = 1'b1;
        flush  = load_start;
        // A request in the load_start cycle would be flushed anyway.
        accept = fetch_req && !stall && !load_start;
      end
      default: ;
    endcase
  end

  assign ready = run;
  assign state = state_q;

  // ------------------------------------------------------------- memory
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[load_addr[WIDX_W+1:2]] <= load_data;
  end

  // Fault decision and read happen at acceptance; faulted slots never read.
  always_comb begin
    new_code = CODE_NONE;
    new_data = NOP_WORD;
    if (fetch_addr[1:0] != 2'b00)  new_code = CODE_ALIGN;
    else if (!in_range(fetch_addr)) new_code = CODE_RANGE;
    else                            new_data = mem_q[fetch_addr[WIDX_W+1:2]];
  end

  // ----------------------------------------------------- fetch pipeline
  // Flush overrides stall so the cycle after load_start is always empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q  <= '0;
      code_q <= '0;
      dat_q  <= {LATENCY{NOP_WORD}};
    end else if (!stall) begin
      vld_q[0]  <= accept;
      code_q[0] <= accept ? new_code : CODE_NONE;
      dat_q[0]  <= accept ? new_data : NOP_WORD;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        code_q[i] <= code_q[i-1];
        dat_q[i]  <= dat_q[i-1];
      end
    end
  end

  assign instr_valid = vld_q[LATENCY-1];
  assign instr       = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : NOP_WORD;
  assign fault_code  = vld_q[LATENCY-1] ? code_q[LATENCY-1] : CODE_NONE;
  assign fault       = vld_q[LATENCY-1] && (code_q[LATENCY-1] != CODE_NONE);

endmodule
